mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the 3-stage core; sits directly downstream of the EX/MEM pipeline register.
- Consumes its M-stage outputs and runs a valid/ready handshake with the data memory.
- Performs store byte-lane steering and load alignment/sign-extension.
- Stalls upstream while an access is in flight, then registers the writeback result (data, rd, write enable) for the register file.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ADDR_W, 32, width of dmem_addr.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- alu_outM  in  XLEN  effective address, or ALU result for non-memory ops
- forward_rs2M  in  XLEN  store data (already forwarded)
- pc_plus4M  in  XLEN  link value
- opcodeM  in  7  0000011 = load, 0100011 = store
- mem_accessM  in  1  instruction in M performs a memory access
- wb_selM  in  2  00 ALU, 01 memory, 10 pc+4, 11 reserved (treated as 00)
- reg_writeM  in  1  writes rd
- rdM  in  5  destination register
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_req_wdata  out  XLEN  lane-shifted store data
- dmem_req_be  out  4  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_rdata  in  XLEN  raw word
- stallM  out  1  freeze PC, IF/EX and EX/MEM registers
- wb_dataW  out  XLEN  writeback value
- rdW  out  5  writeback register
- reg_writeW  out  1  writeback enable

Behaviour:
- Reset values: state = IDLE; all outputs 0. Reset mid-transaction returns to IDLE next edge; any outstanding response is dropped (no WAIT).
- FSM states: IDLE, REQ, WAIT.
- IDLE, mem_accessM = 0:
  - stallM = 0.
  - Next edge: wb_dataW = alu_outM (wb_sel 00/11) or pc_plus4M (10); rdW = rdM; reg_writeW = reg_writeM.
- IDLE, mem_accessM = 1:
  - dmem_req_valid = 1 combinationally from the M inputs; request fields are also latched into internal registers.
  - Store and ready = 1: complete; stallM = 0; reg_writeW = 0 next edge.
  - Load and ready = 1: go to WAIT; stallM = 1.
  - ready = 0: go to REQ; stallM = 1.
- REQ:
  - Drive the latched request; dmem_req_valid held high and the request held stable until ready.
  - On ready: a store completes (stallM deasserts in the same cycle); a load goes to WAIT.
- WAIT:
  - dmem_req_valid = 0; stallM = 1 until dmem_rsp_valid.
  - In the rsp_valid cycle: stallM = 0, next state IDLE, and the formatted load data, rdW and reg_writeW are captured at that edge.
  - A response arriving in the same cycle as acceptance (IDLE/REQ) is illegal; the memory returns data at least 1 cycle after acceptance.
- Minimum latencies:
  - Store: 1 cycle (0 stall cycles).
  - Load: 2 cycles (1 stall cycle).
- reg_writeW is forced to 0 for stores and for every cycle with stallM = 1 (no duplicate writes during stall).
- Store steering, with off = addr[1:0]:
  - SB: be = 0001 << off; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << off; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
- Load formatting: shift rdata right by 8*off, then apply LB/LH sign-extend, LBU/LHU zero-extend, or LW as-is.
- Undefined funct3 (011, 110, 111) with mem_accessM: treated as a word access.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses (LH/SH with off[0] = 1, LW/SW with off != 0) issue no request; stallM stays 0.
  - reg_writeW is forced to 0.
  - Extra output misaligned_trapW (1 bit, reset 0) pulses for one cycle at the next edge; misaligned_addrW (XLEN, reset 0) captures alu_outM.
- Undefined:
  - Ports are absent; misaligned accesses are issued.
  - Enables shift past lane 3 and are truncated to 4 bits (e.g. SH at off 3 gives be = 1000); loads return the shifted bytes with zero fill above.

Test Plan:
- ALU op: wb_selM = 00, alu_outM = 0x0000_1234, rdM = 5, reg_writeM = 1 -> next edge wb_dataW = 0x1234, rdW = 5, reg_writeW = 1, stallM never asserted.
- SB x2 = 0x0000_00AB to addr 0x102, ready = 1 -> same cycle dmem_req_addr = 0x100, be = 0100, wdata = 0xABABABAB, we = 1, stallM = 0; reg_writeW = 0 next edge.
- LB at addr 0x203, ready = 1, rsp_valid 2 cycles later with rdata 0x80FF_0000 -> stallM high 2 cycles, then wb_dataW = 0xFFFF_FF80; same data with LBU -> 0x0000_0080.
- SW with ready low 3 cycles -> state REQ; req_valid, addr and data stable all 3 cycles; stallM high 3 cycles; completes on the 4th cycle.
- LW in WAIT, rst asserted for 1 cycle, then late rsp_valid -> IDLE after reset, response ignored, reg_writeW stays 0, stallM = 0.
- With MISALIGN_TRAP_EN: LW at 0x0000_0006 -> no dmem_req_valid, misaligned_trapW = 1 for one cycle, misaligned_addrW = 0x6, reg_writeW = 0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the M stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// M stage: dmem handshake, store lane steering, load alignment, W-stage result registers.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses are suppressed and reported as a trap.
module mem_access_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          funct3M,
  input  logic [XLEN-1:0]     alu_outM,
  input  logic [XLEN-1:0]     forward_rs2M,
  input  logic [XLEN-1:0]     pc_plus4M,
  input  logic [6:0]          opcodeM,
  input  logic                mem_accessM,
  input  logic [1:0]          wb_selM,
  input  logic                reg_writeM,
  input  logic [4:0]          rdM,
  mem_access_stage_if.master  dmem,
  output logic                stallM,
  output logic [XLEN-1:0]     wb_dataW,
  output logic [4:0]          rdW,
  output logic                reg_writeW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                misaligned_trapW,
  output logic [XLEN-1:0]     misaligned_addrW
`endif
);

  localparam int       NUM_LANES = XLEN / 8;
  localparam bit [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
  logic [XLEN-1:0]       lat_wdata_q, lat_wdata_d;
  logic [3:0]            lat_be_q, lat_be_d;
  logic [2:0]            lat_f3_q, lat_f3_d;
  logic [1:0]            lat_off_q, lat_off_d;
  logic [4:0]            lat_rd_q, lat_rd_d;
  logic                  lat_rw_q, lat_rw_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
`ifdef MISALIGN_TRAP_EN
  logic                  trap_q, trap_d;
  logic [XLEN-1:0]       mis_addr_q, mis_addr_d;
`endif

  logic                  is_store, size_byte, size_half, misaligned;
  logic [1:0]            off;
  logic [3:0]            st_be;
  logic [NUM_LANES-1:0][7:0] st_lanes;
  logic [XLEN-1:0]       wb_alu, ld_shift, ld_data;

  assign is_store  = (opcodeM == OP_STORE);
  assign off       = alu_outM[1:0];
  // Undefined funct3 sizes (011/110/111) fall through to word access.
  assign size_byte = (funct3M[1:0] == 2'b00);
  assign size_half = (funct3M[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mem_accessM &&
                      ((size_half && off[0]) || (!size_byte && !size_half && off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_lanes[i] = size_byte ? forward_rs2M[7:0] :
                         size_half ? forward_rs2M[8*(i%2) +: 8] :
                                     forward_rs2M[8*i +: 8];
  end

  always_comb begin
    if (size_byte)      st_be = 4'b0001 << off;
    else if (size_half) st_be = 4'b0011 << off;
    else                st_be = 4'b1111;
  end

  assign wb_alu   = (wb_selM == 2'b10) ? pc_plus4M : alu_outM;
  assign ld_shift = dmem.rsp_rdata >> {lat_off_q, 3'b000};

  always_comb begin
    case (lat_f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    lat_we_d       = lat_we_q;
    lat_addr_d     = lat_addr_q;
    lat_wdata_d    = lat_wdata_q;
    lat_be_d       = lat_be_q;
    lat_f3_d       = lat_f3_q;
    lat_off_d      = lat_off_q;
    lat_rd_d       = lat_rd_q;
    lat_rw_d       = lat_rw_q;
    wb_data_d      = wb_data_q;
    rd_d           = rd_q;
    reg_write_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d         = 1'b0;
    mis_addr_d     = mis_addr_q;
`endif
    dmem.req_valid = 1'b0;
    dmem.req_we    = lat_we_q;
    dmem.req_addr  = lat_addr_q;
    dmem.req_wdata = lat_wdata_q;
    dmem.req_be    = lat_be_q;
    stallM         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_accessM) begin
          wb_data_d   = wb_alu;
          rd_d        = rdM;
          reg_write_d = reg_writeM;
        end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
          trap_d     = 1'b1;
          mis_addr_d = alu_outM;
`endif
          rd_d       = rdM;
        end else begin
          dmem.req_valid = 1'b1;
          dmem.req_we    = is_store;
          dmem.req_addr  = {alu_outM[ADDR_W-1:2], 2'b00};
          dmem.req_wdata = st_lanes;
          dmem.req_be    = st_be;
          lat_we_d       = is_store;
          lat_addr_d     = {alu_outM[ADDR_W-1:2], 2'b00};
          lat_wdata_d    = st_lanes;
          lat_be_d       = st_be;
          lat_f3_d       = funct3M;
          lat_off_d      = off;
          lat_rd_d       = rdM;
          lat_rw_d       = reg_writeM;
          if (!dmem.req_ready) begin
            state_d = REQ;
            stallM  = 1'b1;
          end else if (!is_store) begin
            state_d = WAIT;
            stallM  = 1'b1;
          end
        end
      end
      REQ: begin
        dmem.req_valid = 1'b1;
        stallM         = 1'b1;
        if (dmem.req_ready) begin
          if (lat_we_q) begin
            state_d = IDLE;
            stallM  = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (dmem.rsp_valid) begin
          stallM      = 1'b0;
          state_d     = IDLE;
          wb_data_d   = ld_data;
          rd_d        = lat_rd_q;
          reg_write_d = lat_rw_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held quiet while reset is asserted.
    if (rst) begin
      dmem.req_valid = 1'b0;
      stallM         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      lat_f3_q    <= '0;
      lat_off_q   <= '0;
      lat_rd_q    <= '0;
      lat_rw_q    <= 1'b0;
      wb_data_q   <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      mis_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      lat_f3_q    <= lat_f3_d;
      lat_off_q   <= lat_off_d;
      lat_rd_q    <= lat_rd_d;
      lat_rw_q    <= lat_rw_d;
      wb_data_q   <= wb_data_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= trap_d;
      mis_addr_q  <= mis_addr_d;
`endif
    end
  end

  assign wb_dataW   = wb_data_q;
  assign rdW        = rd_q;
  assign reg_writeW = reg_write_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_trapW = trap_q;
  assign misaligned_addrW = mis_addr_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed M-stage ops, queued expectations, negedge monitor.
module tb_mem_access_stage;
  localparam bit [6:0] OP_LOAD  = 7'b0000011;
  localparam bit [6:0] OP_STORE = 7'b0100011;
  localparam bit [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  funct3M;
  logic [31:0] alu_outM, forward_rs2M, pc_plus4M;
  logic [6:0]  opcodeM;
  logic        mem_accessM, reg_writeM;
  logic [1:0]  wb_selM;
  logic [4:0]  rdM;
  logic        stallM, reg_writeW;
  logic [31:0] wb_dataW;
  logic [4:0]  rdW;
`ifdef MISALIGN_TRAP_EN
  logic        trapW;
  logic [31:0] trap_addrW;
`endif

  always #5 clk = ~clk;

  mem_access_stage_if #(.XLEN(32), .ADDR_W(32)) dmem_bus ();

  mem_access_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .funct3M(funct3M), .alu_outM(alu_outM),
    .forward_rs2M(forward_rs2M), .pc_plus4M(pc_plus4M), .opcodeM(opcodeM),
    .mem_accessM(mem_accessM), .wb_selM(wb_selM), .reg_writeM(reg_writeM),
    .rdM(rdM), .dmem(dmem_bus), .stallM(stallM), .wb_dataW(wb_dataW),
    .rdW(rdW), .reg_writeW(reg_writeW)
`ifdef MISALIGN_TRAP_EN
    , .misaligned_trapW(trapW), .misaligned_addrW(trap_addrW)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          is_store;
  } req_t;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every accepted request and every register write.
  always @(negedge clk) begin
    req_t er;
    wb_t  ew;
    if (!rst) begin
      if (dmem_bus.req_valid && dmem_bus.req_ready) begin
        if (exp_req.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem_bus.req_addr);
        end else begin
          er = exp_req.pop_front();
          chk("req_we", dmem_bus.req_we, er.we);
          chk("req_addr", dmem_bus.req_addr, er.addr);
          if (er.is_store) begin
            chk("req_wdata", dmem_bus.req_wdata, er.wdata);
            chk("req_be", dmem_bus.req_be, er.be);
          end
        end
      end
      if (reg_writeW) begin
        if (exp_wb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_wb: got rd %0d data %h expected no write", rdW, wb_dataW);
        end else begin
          ew = exp_wb.pop_front();
          chk("wb_data", wb_dataW, ew.data);
          chk("wb_rd", rdW, ew.rd);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_idle;
    mem_accessM = 1'b0; reg_writeM = 1'b0; wb_selM = 2'b00; rdM = 5'd0;
    opcodeM = OP_ALU; funct3M = 3'b000; alu_outM = '0; forward_rs2M = '0; pc_plus4M = '0;
  endtask

  task automatic alu_op(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] exp);
    tick; m_idle;
    wb_selM = sel; alu_outM = alu; pc_plus4M = pc; rdM = rd; reg_writeM = 1'b1;
    exp_wb.push_back('{exp, rd});
    #1 chk("alu_stall", stallM, 1'b0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input int low, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata);
    tick; m_idle;
    mem_accessM = 1'b1; opcodeM = OP_STORE; funct3M = f3; alu_outM = addr;
    forward_rs2M = rs2; rdM = 5'd3; reg_writeM = 1'b1;
    dmem_bus.req_ready = (low == 0);
    exp_req.push_back('{1'b1, e_addr, e_wdata, e_be, 1'b1});
    #1;
    chk("st_valid", dmem_bus.req_valid, 1'b1);
    chk("st_stall", stallM, (low == 0) ? 1'b0 : 1'b1);
    for (int i = 1; i <= low; i++) begin
      tick;
      // Scramble the M inputs: the held request must come from the latch.
      alu_outM = 32'hDEAD_0001; forward_rs2M = 32'h5555_5555;
      dmem_bus.req_ready = (i == low);
      #1;
      chk("req_valid_hold", dmem_bus.req_valid, 1'b1);
      chk("req_addr_hold", dmem_bus.req_addr, e_addr);
      chk("req_wdata_hold", dmem_bus.req_wdata, e_wdata);
      chk("req_stall", stallM, (i == low) ? 1'b0 : 1'b1);
    end
    tick; m_idle; dmem_bus.req_ready = 1'b1;
    chk("st_no_write", reg_writeW, 1'b0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input int wait_n, input logic [31:0] exp, input logic [4:0] rd);
    tick; m_idle;
    mem_accessM = 1'b1; opcodeM = OP_LOAD; funct3M = f3; alu_outM = addr;
    rdM = rd; reg_writeM = 1'b1;
    dmem_bus.req_ready = 1'b1; dmem_bus.rsp_valid = 1'b0;
    exp_req.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0, 4'h0, 1'b0});
    exp_wb.push_back('{exp, rd});
    #1 chk("ld_stall_acc", stallM, 1'b1);
    for (int i = 0; i < wait_n; i++) begin
      tick; dmem_bus.req_ready = 1'b0;
      #1;
      chk("ld_stall_wait", stallM, 1'b1);
      chk("ld_wait_noreq", dmem_bus.req_valid, 1'b0);
      chk("ld_wait_nowr", reg_writeW, 1'b0);
    end
    tick; dmem_bus.req_ready = 1'b0; dmem_bus.rsp_valid = 1'b1; dmem_bus.rsp_rdata = rdata;
    #1 chk("ld_stall_rsp", stallM, 1'b0);
    tick; m_idle; dmem_bus.rsp_valid = 1'b0; dmem_bus.rsp_rdata = 32'h0; dmem_bus.req_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; m_idle;
    dmem_bus.req_ready = 1'b0; dmem_bus.rsp_valid = 1'b0; dmem_bus.rsp_rdata = '0;
    tick; tick;
    chk("rst_stall", stallM, 1'b0);
    chk("rst_req_valid", dmem_bus.req_valid, 1'b0);
    chk("rst_wb_data", wb_dataW, 32'h0);
    chk("rst_rd", rdW, 5'd0);
    chk("rst_reg_write", reg_writeW, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_trap", trapW, 1'b0);
    chk("rst_trap_addr", trap_addrW, 32'h0);
`endif
    rst = 1'b0;

    alu_op(2'b00, 32'h0000_1234, 32'h0000_0044, 5'd5, 32'h0000_1234);
    alu_op(2'b10, 32'h0000_0999, 32'h0000_0044, 5'd7, 32'h0000_0044);
    alu_op(2'b11, 32'h0000_0777, 32'h0000_0048, 5'd8, 32'h0000_0777);
    tick; m_idle;

    do_store(3'b000, 32'h0000_0102, 32'h0000_00AB, 0, 32'h0000_0100, 4'b0100, 32'hABAB_ABAB);
    do_store(3'b001, 32'h0000_0012, 32'h1234_ABCD, 0, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD);
    do_store(3'b010, 32'h0000_0204, 32'hCAFE_BABE, 3, 32'h0000_0204, 4'b1111, 32'hCAFE_BABE);

    do_load(3'b000, 32'h0000_0203, 32'h80FF_0000, 1, 32'hFFFF_FF80, 5'd9);
    do_load(3'b100, 32'h0000_0203, 32'h80FF_0000, 1, 32'h0000_0080, 5'd10);
    do_load(3'b001, 32'h0000_0202, 32'h80FF_0000, 0, 32'hFFFF_80FF, 5'd11);
    do_load(3'b101, 32'h0000_0202, 32'h80FF_0000, 0, 32'h0000_80FF, 5'd12);
    do_load(3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 5'd13);

`ifdef MISALIGN_TRAP_EN
    tick; m_idle;
    mem_accessM = 1'b1; opcodeM = OP_LOAD; funct3M = 3'b010; alu_outM = 32'h0000_0006;
    rdM = 5'd14; reg_writeM = 1'b1; dmem_bus.req_ready = 1'b1;
    #1;
    chk("mis_no_req", dmem_bus.req_valid, 1'b0);
    chk("mis_stall", stallM, 1'b0);
    tick; m_idle;
    chk("mis_trap", trapW, 1'b1);
    chk("mis_addr", trap_addrW, 32'h0000_0006);
    chk("mis_no_write", reg_writeW, 1'b0);
    tick;
    chk("mis_trap_pulse", trapW, 1'b0);
`else
    do_store(3'b001, 32'h0000_0013, 32'h1234_ABCD, 0, 32'h0000_0010, 4'b1000, 32'hABCD_ABCD);
    do_load(3'b001, 32'h0000_0013, 32'hAABB_CCDD, 0, 32'h0000_00AA, 5'd15);
`endif

    // Reset while a load is waiting; the late response must be dropped.
    tick; m_idle;
    mem_accessM = 1'b1; opcodeM = OP_LOAD; funct3M = 3'b010; alu_outM = 32'h0000_0040;
    rdM = 5'd20; reg_writeM = 1'b1; dmem_bus.req_ready = 1'b1;
    exp_req.push_back('{1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0});
    #1 chk("rstw_stall_acc", stallM, 1'b1);
    tick; dmem_bus.req_ready = 1'b0;
    #1 chk("rstw_stall_wait", stallM, 1'b1);
    tick; rst = 1'b1; m_idle;
    #1;
    chk("rstw_stall_rst", stallM, 1'b0);
    chk("rstw_noreq_rst", dmem_bus.req_valid, 1'b0);
    tick; rst = 1'b0; dmem_bus.rsp_valid = 1'b1; dmem_bus.rsp_rdata = 32'h1234_5678;
    #1 chk("rstw_stall_late", stallM, 1'b0);
    tick; dmem_bus.rsp_valid = 1'b0;
    chk("rstw_no_write", reg_writeW, 1'b0);
    tick;

    for (int i = 0; i < 20 && (exp_req.size() != 0 || exp_wb.size() != 0); i++) tick;
    n_cmp++;
    if (exp_req.size() != 0 || exp_wb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d req / %0d wb pending expected 0", exp_req.size(), exp_wb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
